order_tx_framer: RTL
====================

Name: order_tx_framer

Overview:
Exchange-facing order transmitter, the outbound counterpart of the exchange cancellation receive path. Sits after upstream_processor_top. Accepts per-client orders from the CPU side only while the risk check reports safe-to-trade, and buffers them in a small FIFO. Serialises each order as a 5-byte frame on a valid/ready byte stream toward the exchange link.

Parameters:
FIFO_DEPTH, 4, order buffer entries; power of 2, minimum 2.
HDR_BYTE, 8'hA5, frame start byte.

Ports:
clk  input  1  system clock; all logic on rising edge.
HRESETn  input  1  asynchronous active-low reset.
order_go  input  1  single-cycle order strobe, same timing as cpu_go.
order_client_id  input  5  client index for the order.
order_amount  input  16  order quantity.
safe_to_trade  input  1  risk-check result; sampled with order_go.
tx_data  output  8  frame byte.
tx_valid  output  1  tx_data holds a valid byte.
tx_ready  input  1  link accepts the byte this cycle.
tx_last  output  1  high with the checksum byte.
fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
sent_count  output  16  frames fully transmitted; saturates at 16'hFFFF.
drop_count  output  16  orders rejected; saturates at 16'hFFFF.
busy  output  1  FSM not IDLE or FIFO non-empty.

Behaviour:
- Reset: HRESETn low asynchronously clears all state, regardless of clock.
  - Outputs go to tx_data=0, tx_valid=0, tx_last=0, fifo_count=0, sent_count=0, drop_count=0, busy=0.
  - FSM returns to IDLE and the FIFO is emptied.
  - A partially sent frame is abandoned and never resumed.
- Accept rule: an order is pushed on the clock edge where order_go=1 && safe_to_trade=1 && order_amount!=0 && FIFO not full.
  - Fullness is evaluated before any same-cycle pop, so a push while full is dropped even if a pop occurs that cycle.
- Drop rule: order_go=1 with any accept condition false increments drop_count by 1. No other effect.
- FIFO: stores {client_id, amount}, 21 bits per entry. Pointers wrap modulo FIFO_DEPTH.
  - A simultaneous push and pop leaves fifo_count unchanged.
- FSM states: IDLE, HDR, CID, AMT_HI, AMT_LO, CSUM.
  - IDLE: if FIFO non-empty, pop the entry into the frame register and go to HDR. Otherwise stay.
  - HDR/CID/AMT_HI/AMT_LO: advance to the next state on tx_valid && tx_ready.
  - CSUM: on handshake, sent_count increments. If the FIFO is non-empty, pop and go to HDR (back-to-back frames, no idle cycle); otherwise go to IDLE.
- Byte mapping, all registered:
  - HDR = HDR_BYTE
  - CID = {3'b000, client_id}
  - AMT_HI = amount[15:8]
  - AMT_LO = amount[7:0]
  - CSUM = CID ^ AMT_HI ^ AMT_LO (header excluded)
- tx_valid: 1 in every state except IDLE.
- tx_last: 1 only in CSUM.
- Stability: while tx_valid=1 && tx_ready=0, tx_data and tx_last hold their values. The frame register is not modified mid-frame.
- Latency: order_go is sampled at edge T0. The FSM pops at T1, so HDR is valid after T1 (2 cycles).
  - With tx_ready held at 1, a frame takes 5 cycles and back-to-back frames sustain 1 frame per 5 cycles.
- safe_to_trade affects acceptance only. Orders already queued or in flight are always transmitted.
- busy = (state != IDLE) || (fifo_count != 0).

Test Plan:
- Single order, tx_ready=1: order_go with client 3, amount 16'h1234, safe=1 -> bytes A5,03,12,34,25 on 5 consecutive cycles starting 2 cycles after the strobe. tx_last only on 25. sent_count=1.
- Backpressure: same order, tx_ready=0 for 3 cycles while tx_data=8'h12 -> 8'h12 held stable with tx_valid=1. Frame completes intact once ready returns. No byte is lost or duplicated.
- Overflow: FIFO_DEPTH=4, tx_ready=0, 6 orders on consecutive cycles -> first order goes to the frame register, next 4 fill the FIFO, 6th dropped. fifo_count=4, drop_count=1. Releasing tx_ready yields 5 back-to-back frames, then sent_count=5.
- Risk gate and zero amount: order_go with safe_to_trade=0 (client 7, amount 100), then safe=1 with amount 0 -> no tx_valid, drop_count=2, fifo_count=0.
- Reset mid-frame: assert HRESETn=0 during the AMT_HI byte (between clock edges) -> tx_valid=0 immediately. After release: fifo_count=0, all counters 0, next order produces a fresh complete frame starting with A5.
- Push/pop same cycle at full: FIFO full and CSUM handshake coinciding with order_go -> the order is dropped (drop_count+1), fifo_count decrements by 1.

Source files
------------

// File: rtl/order_tx_framer.sv
// order_tx_framer: gates CPU orders on the risk check, queues them in a
// small FIFO and serialises each one as a 5-byte frame
// (header, client id, amount high, amount low, checksum) on a
// valid/ready byte stream toward the exchange link.
module order_tx_framer #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [7:0]  HDR_BYTE   = 8'hA5
) (
    input  logic                          clk,
    input  logic                          HRESETn,
    input  logic                          order_go,
    input  logic [4:0]                    order_client_id,
    input  logic [15:0]                   order_amount,
    input  logic                          safe_to_trade,
    output logic [7:0]                    tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic                          tx_last,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [15:0]                   sent_count,
    output logic [15:0]                   drop_count,
    output logic                          busy
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 21;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_CID,
        S_AMT_HI,
        S_AMT_LO,
        S_CSUM
    } state_e;

    state_e               state_q, state_d;
    logic [ENTRY_W-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [ENTRY_W-1:0]   frame_q, frame_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic [15:0]          sent_q, drop_q;

    logic fifo_full, fifo_empty;
    logic push, pop, reject, frame_done;

    // Byte presented on the link for a given state and frame entry.
    function automatic logic [7:0] frame_byte(state_e s, logic [ENTRY_W-1:0] f);
        logic [7:0] cid, hi, lo;
        cid = {3'b000, f[20:16]};
        hi  = f[15:8];
        lo  = f[7:0];
        case (s)
            S_HDR:    frame_byte = HDR_BYTE;
            S_CID:    frame_byte = cid;
            S_AMT_HI: frame_byte = hi;
            S_AMT_LO: frame_byte = lo;
            S_CSUM:   frame_byte = cid ^ hi ^ lo;
            default:  frame_byte = 8'h00;
        endcase
    endfunction

    // Fullness is judged on the registered count, before any same-cycle pop.
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign push       = order_go && safe_to_trade && (order_amount != 16'h0000) && !fifo_full;
    assign reject     = order_go && !push;

    // Next-state, pop and frame-load decode for the serialiser.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        pop        = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = S_HDR;
                end
            end
            S_HDR:    if (tx_ready) state_d = S_CID;
            S_CID:    if (tx_ready) state_d = S_AMT_HI;
            S_AMT_HI: if (tx_ready) state_d = S_AMT_LO;
            S_AMT_LO: if (tx_ready) state_d = S_CSUM;
            S_CSUM: begin
                if (tx_ready) begin
                    frame_done = 1'b1;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = S_HDR;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        frame_d   = pop ? mem_q[rd_ptr_q] : frame_q;
        // Unchanged state and frame during a stall keep the byte stable.
        tx_data_d = frame_byte(state_d, frame_d);

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Order storage; contents need no reset because the pointers and count
    // define which entries are live.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately left out of reset; only
        // the control state that marks entries valid is cleared.
        if (push) mem_q[wr_ptr_q] <= {order_client_id, order_amount};
    end

    // Control state, frame register, output byte and counters.
    always_ff @(posedge clk or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            frame_q   <= '0;
            tx_data_q <= 8'h00;
            sent_q    <= 16'h0000;
            drop_q    <= 16'h0000;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, regardless of statement order.
            state_q   <= state_d;
            count_q   <= count_d;
            frame_q   <= frame_d;
            tx_data_q <= tx_data_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (frame_done && sent_q != 16'hFFFF) sent_q <= sent_q + 16'd1;
            if (reject && drop_q != 16'hFFFF)     drop_q <= drop_q + 16'd1;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_valid   = (state_q != S_IDLE);
    assign tx_last    = (state_q == S_CSUM);
    assign fifo_count = count_q;
    assign sent_count = sent_q;
    assign drop_count = drop_q;
    assign busy       = (state_q != S_IDLE) || (count_q != '0);

endmodule
